// File: rtl/inert_intf.sv
// Inertial sensor sequencer: power-up wait, SPI init writes, then eight reads per data-ready.
// Optional SPI transaction watchdog enabled by defining INERT_WDOG_EN.
module inert_intf #(
    parameter int unsigned INIT_TMR_W = 16
`ifdef INERT_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC   = 4096
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        vld,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic [15:0] AY,
    output logic [15:0] AZ,
    output logic        err
);

    localparam logic [INIT_TMR_W-1:0] TMR_MAX = '1;
    localparam logic [INIT_TMR_W-1:0] TMR_PRE = TMR_MAX ^ INIT_TMR_W'(1);

    typedef enum logic [1:0] {
        INIT_WAIT,
        CFG_WAIT,
        IDLE,
        RD_WAIT
    } state_t;

    state_t                state, state_d;
    logic [INIT_TMR_W-1:0] timer;
    logic [2:0]            idx, idx_d;
    logic [7:0][7:0]       shadow, shadow_d;
    logic                  int_meta, int_s;
    logic                  done_ok;
    logic                  snd_d, vld_d, err_d;
    logic [15:0]           cmd_d, roll_d, yaw_d, ay_d, az_d;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
        case (i)
            2'd0:    cfg_cmd = 16'h0D02;
            2'd1:    cfg_cmd = 16'h1053;
            2'd2:    cfg_cmd = 16'h1150;
            default: cfg_cmd = 16'h1460;
        endcase
    endfunction

    function automatic logic [7:0] rd_addr(input logic [2:0] i);
        case (i)
            3'd0:    rd_addr = 8'hA2;
            3'd1:    rd_addr = 8'hA3;
            3'd2:    rd_addr = 8'hA6;
            3'd3:    rd_addr = 8'hA7;
            3'd4:    rd_addr = 8'hAA;
            3'd5:    rd_addr = 8'hAB;
            3'd6:    rd_addr = 8'hAC;
            default: rd_addr = 8'hAD;
        endcase
    endfunction

    // A done coinciding with our own snd cannot answer it, so it is not a completion.
    assign done_ok = done && !snd;

`ifdef INERT_WDOG_EN
    localparam int unsigned       WDOG_W    = $clog2(WDOG_CYC) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] wdog;
    logic              timeout;

    assign timeout = (state == CFG_WAIT || state == RD_WAIT) && !done_ok && (wdog == WDOG_LAST);

    // Cycles spent waiting for done since the last snd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (snd_d) begin
            wdog <= '0;
        end else if ((state == CFG_WAIT || state == RD_WAIT) && wdog != WDOG_LAST) begin
            wdog <= wdog + 1'b1;
        end
    end
`endif

    // Two-flop synchroniser for the sensor interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
        end
    end

    // Power-up timer, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT_WAIT;
            idx     <= '0;
            shadow  <= '0;
            snd     <= 1'b0;
            cmd     <= 16'h0000;
            vld     <= 1'b0;
            roll_rt <= 16'h0000;
            yaw_rt  <= 16'h0000;
            AY      <= 16'h0000;
            AZ      <= 16'h0000;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            shadow  <= shadow_d;
            snd     <= snd_d;
            cmd     <= cmd_d;
            vld     <= vld_d;
            roll_rt <= roll_d;
            yaw_rt  <= yaw_d;
            AY      <= ay_d;
            AZ      <= az_d;
            err     <= err_d;
        end
    end

    // Next state, next command and output publication
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        shadow_d = shadow;
        snd_d    = 1'b0;
        cmd_d    = cmd;
        vld_d    = 1'b0;
        roll_d   = roll_rt;
        yaw_d    = yaw_rt;
        ay_d     = AY;
        az_d     = AZ;
        err_d    = err;

        case (state)
            INIT_WAIT: begin
                if (timer == TMR_PRE) begin
                    state_d = CFG_WAIT;
                    idx_d   = '0;
                    snd_d   = 1'b1;
                    cmd_d   = cfg_cmd(2'd0);
                end
            end
            CFG_WAIT: begin
                if (done_ok) begin
                    if (idx == 3'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + 3'd1;
                        snd_d = 1'b1;
                        cmd_d = cfg_cmd(idx_d[1:0]);
                    end
                end
            end
            IDLE: begin
                if (int_s) begin
                    state_d = RD_WAIT;
                    idx_d   = '0;
                    snd_d   = 1'b1;
                    cmd_d   = {rd_addr(3'd0), 8'h00};
                end
            end
            RD_WAIT: begin
                if (done_ok) begin
                    shadow_d[idx] = resp[7:0];
                    if (idx == 3'd7) begin
                        // Last byte goes straight from resp so vld lands one clock after done
                        state_d = IDLE;
                        vld_d   = 1'b1;
                        roll_d  = {shadow_d[1], shadow_d[0]};
                        yaw_d   = {shadow_d[3], shadow_d[2]};
                        ay_d    = {shadow_d[5], shadow_d[4]};
                        az_d    = {shadow_d[7], shadow_d[6]};
                    end else begin
                        idx_d = idx + 3'd1;
                        snd_d = 1'b1;
                        cmd_d = {rd_addr(idx_d), 8'h00};
                    end
                end
            end
            default: state_d = INIT_WAIT;
        endcase

`ifdef INERT_WDOG_EN
        // Stalled transaction: flag it and resend the same command
        if (timeout) begin
            snd_d = 1'b1;
            err_d = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf: SPI responder model, vector table of read sequences,
// hand-written corner sequences (held INT, stray done, watchdog when INERT_WDOG_EN).
module tb_inert_intf;

    localparam int unsigned TMR_W = 4;

    logic        clk = 1'b0;
    logic        rst_n, INT, snd, done, vld, err;
    logic [15:0] cmd, resp, roll_rt, yaw_rt, AY, AZ;
    logic        done_rsp, done_spur;

    assign done = done_rsp | done_spur;

    always #5 clk = ~clk;

    inert_intf #(
        .INIT_TMR_W(TMR_W)
`ifdef INERT_WDOG_EN
        , .WDOG_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .snd(snd), .cmd(cmd),
        .done(done), .resp(resp), .vld(vld), .roll_rt(roll_rt),
        .yaw_rt(yaw_rt), .AY(AY), .AZ(AZ), .err(err)
    );

    typedef struct {
        logic [7:0][7:0] b;
        logic [15:0]     roll, yaw, ay, az;
    } vec_t;

    vec_t        vec [3];
    logic [7:0]  addrs [8] = '{8'hA2, 8'hA3, 8'hA6, 8'hA7, 8'hAA, 8'hAB, 8'hAC, 8'hAD};
    logic [15:0] cfgs  [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [7:0]  rd_byte [256];

    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, last_done_cyc = 0, vld_total = 0, vld_wide = 0;
    int          out_glitch = 0, cmd_moved = 0;
    logic        vld_prev = 1'b0;
    logic [63:0] outs_prev;
    logic [15:0] cmd_log [$];
    int          snd_cyc [$];
    logic [7:0]  hold_addr = 8'h00;
    logic        extra_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: vld width, and outputs may only move together with vld
    always @(negedge clk) begin
        if (done) last_done_cyc = cyc;
        if (vld) vld_total++;
        if (vld && vld_prev) vld_wide++;
        if (!vld && ({roll_rt, yaw_rt, AY, AZ} != outs_prev)) out_glitch++;
        outs_prev = {roll_rt, yaw_rt, AY, AZ};
        vld_prev  = vld;
    end

    // SPI master model: answers each snd 5 clocks later, optional stall and duplicate done
    initial begin
        int          wait_cnt;
        logic [15:0] cur_cmd;
        logic        extra_pend;
        wait_cnt   = -1;
        cur_cmd    = 16'h0;
        extra_pend = 1'b0;
        done_rsp   = 1'b0;
        resp       = 16'h0;
        forever begin
            @(posedge clk); #1;
            done_rsp = 1'b0;
            if (extra_pend) begin
                done_rsp   = 1'b1;
                extra_pend = 1'b0;
            end
            if (!rst_n) begin
                wait_cnt = -1;
            end else if (snd) begin
                cmd_log.push_back(cmd);
                snd_cyc.push_back(cyc);
                cur_cmd = cmd;
                if (cmd[15:8] == hold_addr && hold_addr != 8'h00) begin
                    hold_addr = 8'h00;
                    wait_cnt  = -1;
                end else begin
                    wait_cnt = 5;
                end
            end else if (wait_cnt > 0) begin
                if (cmd != cur_cmd) cmd_moved++;
                wait_cnt--;
                if (wait_cnt == 0) begin
                    done_rsp = 1'b1;
                    resp     = {8'hEE, rd_byte[cur_cmd[15:8]]};
                    if (extra_req) begin
                        extra_pend = 1'b1;
                        extra_req  = 1'b0;
                    end
                    wait_cnt = -1;
                end
            end
        end
    end

    task automatic load_bytes(input logic [7:0][7:0] b);
        for (int i = 0; i < 8; i++) rd_byte[addrs[i]] = b[i];
    endtask

    task automatic wait_vld(input int budget);
        int k;
        k = 0;
        while (!vld && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!vld) chk("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, "_roll"}, 32'(roll_rt), 32'(v.roll));
        chk({tag, "_yaw"},  32'(yaw_rt),  32'(v.yaw));
        chk({tag, "_ay"},   32'(AY),      32'(v.ay));
        chk({tag, "_az"},   32'(AZ),      32'(v.az));
    endtask

    task automatic chk_rd_log(input string tag);
        chk({tag, "_ncmd"}, 32'(cmd_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < cmd_log.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[i]), 32'({addrs[i], 8'h00}));
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
    endtask

    initial begin
        int n, vbase, nlog;

        vec[0].b = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        vec[0].roll = 16'h2211; vec[0].yaw = 16'h4433; vec[0].ay = 16'h6655; vec[0].az = 16'h8877;
        vec[1].b = {8'hAB, 8'hCD, 8'h12, 8'h34, 8'h7F, 8'hFF, 8'h80, 8'h01};
        vec[1].roll = 16'h8001; vec[1].yaw = 16'h7FFF; vec[1].ay = 16'h1234; vec[1].az = 16'hABCD;
        vec[2].b = {8'h66, 8'h99, 8'hC3, 8'h3C, 8'hF0, 8'h0F, 8'h5A, 8'hA5};
        vec[2].roll = 16'h5AA5; vec[2].yaw = 16'hF00F; vec[2].ay = 16'hC33C; vec[2].az = 16'h6699;

        for (int i = 0; i < 256; i++) rd_byte[i] = 8'h00;
        INT = 1'b0; done_spur = 1'b0; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_snd", 32'(snd), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_roll", 32'(roll_rt), 32'h0);
        chk("rst_yaw", 32'(yaw_rt), 32'h0);
        chk("rst_ay", 32'(AY), 32'h0);
        chk("rst_az", 32'(AZ), 32'h0);
        chk("rst_err", 32'(err), 32'd0);

        // Power-up wait: first snd on the 15th clock after release
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (snd) break;
        end
        chk("first_snd_clk", 32'(n), 32'd15);

        repeat (40) @(negedge clk);
        chk("cfg_ncmd", 32'(cmd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < cmd_log.size(); i++)
            chk($sformatf("cfg_cmd%0d", i), 32'(cmd_log[i]), 32'(cfgs[i]));
        chk("cfg_no_vld", 32'(vld_total), 32'd0);

        // Table of read sequences
        for (int v = 0; v < 3; v++) begin
            load_bytes(vec[v].b);
            cmd_log.delete();
            vbase = vld_total;
            pulse_int();
            wait_vld(200);
            chk($sformatf("v%0d_latency", v), 32'(cyc - last_done_cyc), 32'd1);
            chk_outs($sformatf("v%0d", v), vec[v]);
            repeat (5) @(negedge clk);
            chk_rd_log($sformatf("v%0d", v));
            chk($sformatf("v%0d_nvld", v), 32'(vld_total - vbase), 32'd1);
        end

        // Stray done in IDLE must change nothing
        nlog = cmd_log.size();
        vbase = vld_total;
        done_spur = 1'b1;
        @(negedge clk);
        done_spur = 1'b0;
        repeat (10) @(negedge clk);
        chk("spur_idle_nsnd", 32'(cmd_log.size()), 32'(nlog));
        chk("spur_idle_nvld", 32'(vld_total - vbase), 32'd0);
        chk("spur_idle_cmd", 32'(cmd), 32'hAD00);
        chk_outs("spur_idle", vec[2]);

        // Duplicate done right after a real one must not skip a read
        load_bytes(vec[0].b);
        cmd_log.delete();
        vbase = vld_total;
        extra_req = 1'b1;
        pulse_int();
        wait_vld(200);
        chk_outs("dup", vec[0]);
        repeat (5) @(negedge clk);
        chk_rd_log("dup");
        chk("dup_nvld", 32'(vld_total - vbase), 32'd1);

        // INT held across vld restarts a read within 3 clocks
        load_bytes(vec[1].b);
        cmd_log.delete();
        vbase = vld_total;
        INT = 1'b1;
        wait_vld(200);
        chk_outs("held1", vec[1]);
        nlog = cmd_log.size();
        repeat (3) @(negedge clk);
        chk("held_resnd", 32'(cmd_log.size()), 32'(nlog + 1));
        if (cmd_log.size() > 0) chk("held_resnd_cmd", 32'(cmd_log[cmd_log.size() - 1]), 32'hA200);
        INT = 1'b0;
        load_bytes(vec[2].b);
        wait_vld(200);
        chk_outs("held2", vec[2]);
        repeat (20) @(negedge clk);
        chk("held_nvld", 32'(vld_total - vbase), 32'd2);
        chk("held_ncmd", 32'(cmd_log.size()), 32'd16);
        chk("err_clear", 32'(err), 32'd0);

`ifdef INERT_WDOG_EN
        // Stall the A6 read: flag, resend after 16 clocks, finish normally
        load_bytes(vec[0].b);
        cmd_log.delete();
        snd_cyc.delete();
        hold_addr = 8'hA6;
        pulse_int();
        wait_vld(300);
        chk_outs("wdog", vec[0]);
        chk("wdog_err", 32'(err), 32'd1);
        chk("wdog_ncmd", 32'(cmd_log.size()), 32'd9);
        if (cmd_log.size() >= 4) begin
            chk("wdog_first_a6", 32'(cmd_log[2]), 32'hA600);
            chk("wdog_resnd_a6", 32'(cmd_log[3]), 32'hA600);
            chk("wdog_gap", 32'(snd_cyc[3] - snd_cyc[2]), 32'd16);
        end
        repeat (10) @(negedge clk);
        chk("wdog_err_sticky", 32'(err), 32'd1);
`endif

        chk("cmd_stable", 32'(cmd_moved), 32'd0);
        chk("out_atomic", 32'(out_glitch), 32'd0);
        chk("vld_one_cycle", 32'(vld_wide), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
